// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// funct codes, iteration mode and FSM state encoding.
package muldiv_pkg;

  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MTLO  = 6'h13;

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: a shift-add step
// for multiply or a restoring step for divide.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               mode_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               qbit_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rsh;
  logic [WIDTH:0] trial;

  // Multiply: add operand to upper half when the low bit is set,
  // then shift right. Divide: shift left, trial subtract, keep
  // the difference when it does not borrow.
  always_comb begin
    sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
        + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rsh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    trial = rsh - {1'b0, opnd_i};
    qbit_o = 1'b0;
    acc_o = '0;
    if (mode_i == MD_DIV) begin
      qbit_o = ~trial[WIDTH];
      acc_o = {(qbit_o ? trial[WIDTH-1:0] : rsh[WIDTH-1:0]),
               acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/exec_muldiv.sv
// Multi-cycle multiply/divide unit owning HI/LO. Operates on
// magnitudes for WIDTH cycles, then fixes signs in one cycle.
module exec_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       Function_opcode,
  input  logic [WIDTH-1:0] Read_data_1,
  input  logic [WIDTH-1:0] Read_data_2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI_out,
  output logic [WIDTH-1:0] LO_out
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             op_mul, op_div;
  logic             op_mthi, op_mtlo;
  logic             op_sgn;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  logic [W2-1:0]    step_acc;
  logic             step_q;

  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;

  assign op_mul  = (Function_opcode == FN_MULT)
                 | (Function_opcode == FN_MULTU);
  assign op_div  = (Function_opcode == FN_DIV)
                 | (Function_opcode == FN_DIVU);
  assign op_mthi = (Function_opcode == FN_MTHI);
  assign op_mtlo = (Function_opcode == FN_MTLO);
  assign op_sgn  = (Function_opcode == FN_MULT)
                 | (Function_opcode == FN_DIV);

  // MIN maps to 2^(WIDTH-1), which the unsigned path holds.
  assign a_neg = op_sgn & Read_data_1[WIDTH-1];
  assign b_neg = op_sgn & Read_data_2[WIDTH-1];
  assign a_abs = a_neg ? -Read_data_1 : Read_data_1;
  assign b_abs = b_neg ? -Read_data_2 : Read_data_2;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .mode_i (div_q),
    .acc_i  (acc_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .qbit_o (step_q)
  );

  // Divide-by-zero leaves all ones in the quotient; the
  // remainder negation restores the raw dividend.
  assign prod = negq_q ? -acc_q : acc_q;
  assign quo  = dz_q ? '1
              : (negq_q ? -acc_q[WIDTH-1:0]
                        : acc_q[WIDTH-1:0]);
  assign rem  = negr_q ? -acc_q[W2-1:WIDTH]
                       : acc_q[W2-1:WIDTH];

  // Next-state, datapath load/iterate and result write-back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !flush) begin
          unique case (1'b1)
            op_mthi: begin
              hi_d   = Read_data_1;
              done_d = 1'b1;
            end
            op_mtlo: begin
              lo_d   = Read_data_1;
              done_d = 1'b1;
            end
            op_mul, op_div: begin
              acc_d   = {{WIDTH{1'b0}},
                         op_div ? a_abs : b_abs};
              opnd_d  = op_div ? b_abs : a_abs;
              div_d   = op_div;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              dz_d    = op_div & (Read_data_2 == '0);
              cnt_d   = CNT_W'(WIDTH);
              state_d = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc | W2'(step_q);
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          if (div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            {hi_d, lo_d} = prod;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and architectural registers, cleared asynchronously.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign HI_out = hi_q;
  assign LO_out = lo_q;

endmodule

// File: tb/tb_exec_muldiv.sv
// Randomised bench for exec_muldiv at WIDTH=32 and WIDTH=8,
// checked against an integer-arithmetic reference model.
module tb_exec_muldiv;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [5:0]  fn = 6'h0;
  logic [31:0] rs = '0;
  logic [31:0] rt = '0;

  logic        busy32, done32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  int checks = 0;
  int failures = 0;

  logic [63:0] m_hi32 = '0, m_lo32 = '0;
  logic [63:0] m_hi8 = '0, m_lo8 = '0;

  always #5 clk = ~clk;

  exec_muldiv #(.WIDTH(32)) dut32 (
    .clock           (clk),
    .reset_n         (rst_n),
    .start           (start),
    .Function_opcode (fn),
    .Read_data_1     (rs),
    .Read_data_2     (rt),
    .flush           (flush),
    .busy            (busy32),
    .done            (done32),
    .HI_out          (hi32),
    .LO_out          (lo32)
  );

  exec_muldiv #(.WIDTH(8)) dut8 (
    .clock           (clk),
    .reset_n         (rst_n),
    .start           (start),
    .Function_opcode (fn),
    .Read_data_1     (rs[7:0]),
    .Read_data_2     (rt[7:0]),
    .flush           (flush),
    .busy            (busy8),
    .done            (done8),
    .HI_out          (hi8),
    .LO_out          (lo8)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit valid_fn(input logic [5:0] f);
    return f inside {FN_MULT, FN_MULTU, FN_DIV,
                     FN_DIVU, FN_MTHI, FN_MTLO};
  endfunction

  // Architectural result of one op on a w-bit machine.
  function automatic void ref_op(
    input  int          w,
    input  logic [5:0]  f,
    input  logic [63:0] a_in, b_in, hi0, lo0,
    output logic [63:0] hi, lo);
    logic [63:0] mask, a, b, pu;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    a = a_in & mask;
    b = b_in & mask;
    sa = a[w-1] ? longint'(a) - longint'(64'd1 << w)
                : longint'(a);
    sb = b[w-1] ? longint'(b) - longint'(64'd1 << w)
                : longint'(b);
    hi = hi0;
    lo = lo0;
    case (f)
      FN_MULT: begin
        pu = 64'(sa * sb);
        lo = pu & mask;
        hi = (pu >> w) & mask;
      end
      FN_MULTU: begin
        pu = a * b;
        lo = pu & mask;
        hi = (pu >> w) & mask;
      end
      FN_DIV: begin
        if (b == 0) begin
          lo = mask;
          hi = a;
        end else begin
          q = sa / sb;
          r = sa % sb;
          lo = 64'(q) & mask;
          hi = 64'(r) & mask;
        end
      end
      FN_DIVU: begin
        if (b == 0) begin
          lo = mask;
          hi = a;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      FN_MTHI: hi = a;
      FN_MTLO: lo = a;
      default: ;
    endcase
  endfunction

  task automatic run_op(input logic [5:0]  f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit          intr);
    logic [63:0] eh32, el32, eh8, el8;
    bit v, mt, f32, f8;
    int bc32, bc8, dh32, dh8, ebc32, ebc8;
    v  = valid_fn(f);
    mt = (f == FN_MTHI) || (f == FN_MTLO);
    ref_op(32, f, 64'(a), 64'(b), m_hi32, m_lo32,
           eh32, el32);
    ref_op(8, f, 64'(a), 64'(b), m_hi8, m_lo8,
           eh8, el8);
    ebc32 = (v && !mt) ? 33 : 0;
    ebc8  = (v && !mt) ? 9 : 0;
    f32 = 0; f8 = 0;
    bc32 = 0; bc8 = 0; dh32 = 0; dh8 = 0;
    @(negedge clk);
    fn = f; rs = a; rt = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (intr && i == 4) begin
        start = 1'b1;
        fn = FN_DIVU;
        rs = $urandom;
        rt = $urandom;
      end
      if (intr && i == 5) start = 1'b0;
      if (!f32) begin
        if (busy32) begin
          bc32++;
          dh32 += int'(done32);
        end else begin
          f32 = 1;
          check("busy_len32", 64'(bc32), 64'(ebc32));
          check("done_early32", 64'(dh32), 64'd0);
          check("done32", 64'(done32), 64'(v));
          check("hi32", 64'(hi32), eh32);
          check("lo32", 64'(lo32), el32);
        end
      end
      if (!f8) begin
        if (busy8) begin
          bc8++;
          dh8 += int'(done8);
        end else begin
          f8 = 1;
          check("busy_len8", 64'(bc8), 64'(ebc8));
          check("done_early8", 64'(dh8), 64'd0);
          check("done8", 64'(done8), 64'(v));
          check("hi8", 64'(hi8), eh8);
          check("lo8", 64'(lo8), el8);
        end
      end
      if (f32 && f8) break;
      @(negedge clk);
    end
    start = 1'b0;
    check("timeout32", 64'(f32), 64'd1);
    check("timeout8", 64'(f8), 64'd1);
    @(negedge clk);
    check("done_pulse32", 64'(done32), 64'd0);
    check("done_pulse8", 64'(done8), 64'd0);
    if (v) begin
      m_hi32 = eh32; m_lo32 = el32;
      m_hi8 = eh8; m_lo8 = el8;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'h0000_0080;
      6: return 32'h0000_007F;
      default: return $urandom;
    endcase
  endfunction

  task automatic check_idle_hold(input string tag);
    check({tag, "_busy32"}, 64'(busy32), 64'd0);
    check({tag, "_done32"}, 64'(done32), 64'd0);
    check({tag, "_hi32"}, 64'(hi32), m_hi32);
    check({tag, "_lo32"}, 64'(lo32), m_lo32);
    check({tag, "_busy8"}, 64'(busy8), 64'd0);
    check({tag, "_done8"}, 64'(done8), 64'd0);
    check({tag, "_hi8"}, 64'(hi8), m_hi8);
    check({tag, "_lo8"}, 64'(lo8), m_lo8);
  endtask

  initial begin
    logic [5:0] fns [7];
    int dcnt;
    fns = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU,
            FN_MTHI, FN_MTLO, 6'h10};

    repeat (3) @(negedge clk);
    check_idle_hold("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'h2, 0);
    run_op(FN_MULT, 32'hFFFF_FFF9, 32'h3, 0);
    run_op(FN_DIV, 32'hFFFF_FFF9, 32'h2, 0);
    run_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(FN_DIV, 32'h0000_0080, 32'h0000_00FF, 0);
    run_op(FN_DIVU, 32'd100, 32'd0, 0);
    run_op(FN_DIV, 32'h8000_0080, 32'h0, 0);

    // mthi then mtlo on consecutive cycles
    @(negedge clk);
    fn = FN_MTHI; rs = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk);
    check("mthi_done", 64'(done32), 64'd1);
    check("mthi_busy", 64'(busy32), 64'd0);
    check("mthi_hi", 64'(hi32), 64'hDEAD_BEEF);
    check("mthi_hi8", 64'(hi8), 64'hEF);
    fn = FN_MTLO; rs = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_done", 64'(done32), 64'd1);
    check("mtlo_busy", 64'(busy32), 64'd0);
    check("mtlo_lo", 64'(lo32), 64'h1234);
    check("mtlo_lo8", 64'(lo8), 64'h34);
    @(negedge clk);
    check("mt_done_end", 64'(done32), 64'd0);
    m_hi32 = 64'hDEAD_BEEF; m_lo32 = 64'h1234;
    m_hi8 = 64'hEF; m_lo8 = 64'h34;

    // flush mid-run: HI/LO untouched, no done
    @(negedge clk);
    fn = FN_DIVU; rs = 32'd100; rt = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_flush_busy32", 64'(busy32), 64'd1);
    check("pre_flush_busy8", 64'(busy8), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_idle_hold("flush");
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      dcnt += int'(done32) + int'(done8);
    end
    check("flush_no_done", 64'(dcnt), 64'd0);
    check_idle_hold("flush_late");

    // flush together with start drops the start
    fn = FN_MTHI; rs = 32'h5555_AAAA;
    start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check_idle_hold("flush_start");

    // start while busy is ignored
    run_op(FN_MULT, 32'h1234_5678, 32'hFFFF_0003, 1);

    // random ops, including unaccepted funct codes
    for (int n = 0; n < 50; n++) begin
      run_op(fns[$urandom_range(0, 6)], pick(), pick(),
             ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset mid-run
    @(negedge clk);
    fn = FN_MULTU; rs = 32'hFFFF_FFFF; rt = 32'hFFFF_FFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    m_hi32 = '0; m_lo32 = '0; m_hi8 = '0; m_lo8 = '0;
    check_idle_hold("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(FN_MULTU, 32'hFFFF_FFFF, 32'h2, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
